// File: rtl/music_box_pkg.sv
// music_box_pkg: note codes, tone period constants, FSM encoding and song ROM word layout
package music_box_pkg;
  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] C = 4'd1;
  localparam logic [3:0] D = 4'd2;
  localparam logic [3:0] E = 4'd3;
  localparam logic [3:0] F = 4'd4;
  localparam logic [3:0] G = 4'd5;
  localparam logic [3:0] A = 4'd6;
  localparam logic [3:0] B = 4'd7;
  localparam logic [3:0] CC = 4'd8;
  localparam logic [3:0] END = 4'd15;
  localparam logic [31:0] HZ_C = 32'd191109;
  localparam logic [31:0] HZ_D = 32'd170265;
  localparam logic [31:0] HZ_E = 32'd151685;
  localparam logic [31:0] HZ_F = 32'd143172;
  localparam logic [31:0] HZ_G = 32'd127551;
  localparam logic [31:0] HZ_A = 32'd113636;
  localparam logic [31:0] HZ_B = 32'd101239;
  localparam logic [31:0] HZ_CC = 32'd95556;
  localparam int CODE_LSB = 12;
  localparam int DUR_LSB = 4;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_LATCH = 3'd2;
  localparam state_t S_PLAY = 3'd3;
  localparam state_t S_GAP = 3'd4;
  function automatic logic is_tone(input logic [3:0] code);
    return code >= C && code <= CC;
  endfunction
  function automatic logic [31:0] note_to_hz(input logic [3:0] code);
    case (code)
      C: return HZ_C;
      D: return HZ_D;
      E: return HZ_E;
      F: return HZ_F;
      G: return HZ_G;
      A: return HZ_A;
      B: return HZ_B;
      CC: return HZ_CC;
      default: return 32'd0;
    endcase
  endfunction
endpackage

// File: rtl/music_box_sequencer_if.sv
// music_box_sequencer_if: song ROM read port and tone-generator drive of the sequencer
interface music_box_sequencer_if #(parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0] rom_data;
  logic play_note;
  logic [31:0] hz;
  modport master (output rom_addr, play_note, hz, input rom_data);
  modport slave (input rom_addr, play_note, hz, output rom_data);
endinterface

// File: rtl/music_box_sequencer_tick_prescaler.sv
// tick_prescaler: one-cycle tick every TICK_DIV enabled cycles; reload restarts a full period
module tick_prescaler #(
  parameter int TICK_DIV = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic reload,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] r_cnt;
  assign tick = enable && r_cnt == '0;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else if (reload || tick) r_cnt <= CW'(TICK_DIV - 1);
    else if (enable) r_cnt <= r_cnt - 1'b1;
endmodule

// File: rtl/music_box_sequencer.sv
// music_box_sequencer: plays note events from a synchronous song ROM into one tone generator,
// with tick-timed durations, an articulation gap, pause/stop and looping
module music_box_sequencer import music_box_pkg::*; #(
  parameter int TICK_DIV = 500000,
  parameter int GAP_TICKS = 2,
  parameter int ADDR_W = 6
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic stop,
  input  logic pause,
  input  logic loop_en,
  music_box_sequencer_if.master bus,
  output logic busy,
  output logic done
);
  state_t r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0] r_dur;
  logic [31:0] r_hz;
  logic r_play, r_done;
  logic w_tick, w_reload, w_run, w_last_tick, w_adv_done, w_unused;
  logic [3:0] w_code;
  logic [7:0] w_len;
  logic [ADDR_W-1:0] w_next_addr;
  state_t w_adv_state;
  assign w_code = bus.rom_data[CODE_LSB +: 4];
  assign w_len = bus.rom_data[DUR_LSB +: 8];
  assign w_unused = ^bus.rom_data[3:0];
  assign w_reload = r_state != S_PLAY && r_state != S_GAP;
  assign w_run = !w_reload && !pause;
  assign w_last_tick = w_tick && r_dur == 8'd1;
  assign w_next_addr = r_addr + 1'b1;
  assign w_adv_done = r_addr == '1 && !loop_en;
  assign w_adv_state = w_adv_done ? S_IDLE : S_FETCH;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clock(clock),
    .resetn(resetn),
    .reload(w_reload),
    .enable(w_run),
    .tick(w_tick)
  );
  // r_dur counts remaining ticks of the current note, then of the gap
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_dur <= '0;
      r_hz <= '0;
      r_play <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_play <= 1'b0;
      end else case (r_state)
        S_IDLE: if (start && !stop) begin
          r_addr <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: if (!pause) r_state <= S_LATCH;
        S_LATCH: if (!pause) begin
          if (w_code == END) begin
            if (loop_en) r_addr <= '0;
            r_state <= loop_en ? S_FETCH : S_IDLE;
            r_done <= !loop_en;
          end else if (w_len == 8'd0) begin
            r_addr <= w_next_addr;
            r_state <= w_adv_state;
            r_done <= w_adv_done;
          end else begin
            r_hz <= is_tone(w_code) ? note_to_hz(w_code) : r_hz;
            r_play <= is_tone(w_code);
            r_dur <= w_len;
            r_state <= S_PLAY;
          end
        end
        S_PLAY: if (w_last_tick) begin
          r_play <= 1'b0;
          if (GAP_TICKS > 0) begin
            r_dur <= 8'(GAP_TICKS);
            r_state <= S_GAP;
          end else begin
            r_addr <= w_next_addr;
            r_state <= w_adv_state;
            r_done <= w_adv_done;
          end
        end else if (w_tick) r_dur <= r_dur - 1'b1;
        S_GAP: if (w_last_tick) begin
          r_addr <= w_next_addr;
          r_state <= w_adv_state;
          r_done <= w_adv_done;
        end else if (w_tick) r_dur <= r_dur - 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  assign bus.rom_addr = r_addr;
  assign bus.hz = r_hz;
  assign bus.play_note = r_play && !pause;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
endmodule

// File: tb/tb_music_box_sequencer.sv
// tb_music_box_sequencer: directed playback scenarios checked every cycle against a
// cycle-count playback model, plus hand-computed timing expectations per scenario
module tb_music_box_sequencer;
  localparam int TD = 4;
  localparam int GT = 1;
  localparam int AW = 3;
  localparam logic [AW-1:0] LAST = '1;
  logic clock = 1'b0, resetn = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic busy, done;
  logic [15:0] rom [0:7];
  int checks = 0, errors = 0;
  bit cmp_en = 1'b0;
  music_box_sequencer_if #(.ADDR_W(AW)) bus ();
  music_box_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT), .ADDR_W(AW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .bus(bus.master), .busy(busy), .done(done));
  always #5 clock = ~clock;
  always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_hz(input logic [3:0] c);
    case (c)
      4'd1: return 32'd191109;
      4'd2: return 32'd170265;
      4'd3: return 32'd151685;
      4'd4: return 32'd143172;
      4'd5: return 32'd127551;
      4'd6: return 32'd113636;
      4'd7: return 32'd101239;
      4'd8: return 32'd95556;
      default: return 32'd0;
    endcase
  endfunction

  // Model: each phase is tracked as a count of remaining un-paused cycles
  typedef enum {M_IDLE, M_FETCH, M_LATCH, M_PLAY, M_GAP} mph_t;
  mph_t m_ph;
  int m_left;
  logic [AW-1:0] m_addr;
  logic [31:0] m_hz;
  logic m_play, m_done;
  function automatic logic [3:0] code_of();
    return rom[m_addr][15:12];
  endfunction
  function automatic int len_of();
    return int'(rom[m_addr][11:4]);
  endfunction
  function automatic logic adv_done();
    return m_addr == LAST && !loop_en;
  endfunction
  function automatic mph_t adv_ph();
    return adv_done() ? M_IDLE : M_FETCH;
  endfunction
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_ph <= M_IDLE; m_left <= 0; m_addr <= '0; m_hz <= '0; m_play <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (stop && m_ph != M_IDLE) begin
        m_ph <= M_IDLE;
        m_play <= 1'b0;
      end else if (m_ph == M_IDLE) begin
        if (start && !stop) begin m_ph <= M_FETCH; m_addr <= '0; end
      end else if (!pause) begin
        case (m_ph)
          M_FETCH: m_ph <= M_LATCH;
          M_LATCH:
            if (code_of() == 4'd15) begin
              if (loop_en) begin m_addr <= '0; m_ph <= M_FETCH; end
              else begin m_ph <= M_IDLE; m_done <= 1'b1; end
            end else if (len_of() == 0) begin
              m_addr <= m_addr + 1'b1; m_ph <= adv_ph(); m_done <= adv_done();
            end else begin
              if (code_of() >= 4'd1 && code_of() <= 4'd8) m_hz <= exp_hz(code_of());
              m_play <= code_of() >= 4'd1 && code_of() <= 4'd8;
              m_left <= len_of() * TD;
              m_ph <= M_PLAY;
            end
          M_PLAY:
            if (m_left == 1) begin
              m_play <= 1'b0;
              if (GT > 0) begin m_left <= GT * TD; m_ph <= M_GAP; end
              else begin m_addr <= m_addr + 1'b1; m_ph <= adv_ph(); m_done <= adv_done(); end
            end else m_left <= m_left - 1;
          default:
            if (m_left == 1) begin
              m_addr <= m_addr + 1'b1; m_ph <= adv_ph(); m_done <= adv_done();
            end else m_left <= m_left - 1;
        endcase
      end
    end
  end

  always @(negedge clock) if (cmp_en) begin
    chk("play_note", bus.play_note, m_play && !pause);
    chk("hz", bus.hz, m_hz);
    chk("busy", busy, m_ph != M_IDLE);
    chk("done", done, m_done);
    chk("rom_addr", bus.rom_addr, m_addr);
  end

  function automatic logic [15:0] ev(input int code, input int dur);
    return {code[3:0], dur[7:0], 4'h0};
  endfunction
  task automatic clear_rom();
    for (int k = 0; k < 8; k++) rom[k] = ev(15, 0);
  endtask

  int first_hi, hi_cnt, rises, done_cnt, done_cyc, pause_hi, stop_busy, stop_play;
  // Pulse start, then observe n cycles; cycle 1 is the first after start is sampled
  task automatic run(input int n, input int p_at, input int s_at);
    logic prev = 1'b0;
    first_hi = -1; hi_cnt = 0; rises = 0; done_cnt = 0; done_cyc = -1;
    pause_hi = 0; stop_busy = -1; stop_play = -1;
    @(negedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      if (bus.play_note) begin hi_cnt++; if (first_hi < 0) first_hi = i; end
      if (bus.play_note && !prev) rises++;
      prev = bus.play_note;
      if (pause && bus.play_note) pause_hi++;
      if (done) begin done_cnt++; done_cyc = i; end
      if (i == s_at + 1) begin stop_busy = int'(busy); stop_play = int'(bus.play_note); end
      #1 pause = i >= p_at && i < p_at + 5;
      stop = i == s_at;
    end
    pause = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    clear_rom();
    #1 resetn = 1'b0;
    #1 cmp_en = 1'b1;
    chk("rst_play", bus.play_note, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus.rom_addr, 0);
    repeat (2) @(negedge clock);
    #1 resetn = 1'b1;

    rom[0] = ev(1, 2);
    run(25, -100, -10);
    chk("s1_first_hi", first_hi, 3);
    chk("s1_hi_cnt", hi_cnt, 8);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_done_cyc", done_cyc, 17);
    chk("s1_busy_end", busy, 0);
    chk("s1_hz_hold", bus.hz, 191109);

    clear_rom();
    rom[0] = ev(0, 1); rom[1] = ev(3, 1);
    run(25, -100, -10);
    chk("s2_first_hi", first_hi, 13);
    chk("s2_hi_cnt", hi_cnt, 4);
    chk("s2_hz", bus.hz, 151685);
    chk("s2_done_cyc", done_cyc, 23);

    clear_rom();
    rom[0] = ev(5, 3);
    run(32, 6, -10);
    chk("s3_first_hi", first_hi, 3);
    chk("s3_hi_cnt", hi_cnt, 12);
    chk("s3_pause_hi", pause_hi, 0);
    chk("s3_hz", bus.hz, 127551);
    chk("s3_done_cyc", done_cyc, 26);

    clear_rom();
    rom[0] = ev(6, 1);
    loop_en = 1'b1;
    run(30, -100, 29);
    loop_en = 1'b0;
    chk("s4_first_hi", first_hi, 3);
    chk("s4_rises", rises, 3);
    chk("s4_hi_cnt", hi_cnt, 11);
    chk("s4_done_cnt", done_cnt, 0);
    chk("s4_stop_busy", stop_busy, 0);
    chk("s4_stop_play", stop_play, 0);
    chk("s4_hz", bus.hz, 113636);

    @(negedge clock); #1 start = 1'b1; stop = 1'b1;
    @(negedge clock);
    chk("s5_start_stop_busy", busy, 0);
    #1 start = 1'b0; stop = 1'b0;

    clear_rom();
    rom[0] = ev(1, 2);
    run(5, -100, -10);
    chk("s6_playing", bus.play_note, 1);
    #2 resetn = 1'b0;
    #1;
    chk("s6_rst_play", bus.play_note, 0);
    chk("s6_rst_hz", bus.hz, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_addr", bus.rom_addr, 0);
    @(negedge clock); #1 resetn = 1'b1;

    for (int k = 0; k < 8; k++) rom[k] = ev(k + 1, 1);
    run(85, -100, -10);
    chk("s7_rises", rises, 8);
    chk("s7_done_cnt", done_cnt, 1);
    chk("s7_done_cyc", done_cyc, 81);
    chk("s7_hz", bus.hz, 95556);
    chk("s7_busy_end", busy, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/music_box_sequencer.md
Name: music_box_sequencer

Overview:
- Playback controller for the music-box half of the piano/music-box design.
- Reads note events from an external synchronous song ROM and drives one square-wave tone generator through a play_note/hz pair.
- Times each note in prescaled ticks, inserts an articulation gap after each event, and supports start/stop/pause/loop.
- Sits between the song ROM and one tone-generator instance; the generator output is summed into the audio controller mix.

Parameters:
- TICK_DIV, 500000, clock cycles per duration tick (10 ms at 50 MHz); must be >= 2.
- GAP_TICKS, 2, silent ticks inserted after every note or rest event; 0 means no gap.
- ADDR_W, 6, song ROM address width; song depth is 2**ADDR_W.

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin playback at address 0.
- stop  in  1  single-cycle request to abort playback.
- pause  in  1  level; while high, playback is frozen and muted.
- loop_en  in  1  level; on END or address wrap, restart at 0 instead of finishing.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  16  ROM word, valid one cycle after rom_addr. [15:12] note code, [11:4] duration in ticks, [3:0] reserved.
- play_note  out  1  tone-generator enable.
- hz  out  32  half-period/period constant to the tone generator.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when playback finishes without looping.

Behaviour:
- Reset is asynchronous and active-low; all of the following take effect immediately:
  - state = IDLE, rom_addr = 0.
  - play_note = 0, hz = 0, busy = 0, done = 0.
  - tick and duration counters = 0.
- Note codes:
  - 0 = rest.
  - 1..8 = C, D, E, F, G, A, B, C' with hz values 191109, 170265, 151685, 143172, 127551, 113636, 101239, 95556.
  - 9..14 = reserved, treated as rest.
  - 15 = END.
- FSM states and transitions:
  - IDLE: on start, rom_addr <= 0, go to FETCH. stop is ignored.
  - FETCH: one cycle with the address presented, then LATCH.
  - LATCH: rom_data is valid in this cycle. Decode:
    - END: if loop_en, rom_addr <= 0 and go to FETCH; else pulse done and go to IDLE.
    - duration == 0: skip the event; advance the address and go to FETCH.
    - otherwise: load hz (rest or reserved code leaves hz at its previous value), load the duration counter, set play_note = (code is 1..8), go to PLAY.
  - PLAY: lasts exactly duration*TICK_DIV un-paused cycles, then:
    - play_note <= 0;
    - go to GAP if GAP_TICKS > 0, else advance the address and go to FETCH.
  - GAP: lasts exactly GAP_TICKS*TICK_DIV un-paused cycles; play_note stays 0; then advance the address and go to FETCH.
- Address advance: rom_addr + 1. At 2**ADDR_W-1 the address wraps to 0 if loop_en; otherwise pulse done and go to IDLE.
- Prescaler: reloads to TICK_DIV-1 on entry to PLAY and GAP. The tick fires when the prescaler hits 0, so the first tick is a full period.
- Event latency: start sampled at cycle 0 gives play_note high and hz valid from cycle 3 (IDLE -> FETCH -> LATCH -> PLAY).
- Inter-event overhead: 2 cycles (FETCH and LATCH) with play_note low.
- pause:
  - Freezes the prescaler, the duration counter and the state.
  - Forces play_note to 0 combinationally.
  - On release, resumes with the remaining count intact.
  - pause in FETCH or LATCH holds that state.
- stop: in any non-IDLE state, next cycle gives state = IDLE, play_note = 0, busy = 0. No done pulse.
- start and stop in the same cycle: stop wins; from IDLE, stay in IDLE.
- start while busy: ignored.
- loop_en is sampled only at END or address wrap.
- hz holds its last value in IDLE; only play_note gates the sound.

Decomposition:
- Shared package music_box_pkg:
  - note-code constants (REST, END, C..CC);
  - the 8 hz period constants plus a note_to_hz function;
  - the FSM state enum;
  - the rom_data field positions.
- One sub-module, tick_prescaler (parameter TICK_DIV):
  - inputs clock, resetn, reload, enable;
  - output tick.

Test Plan (TICK_DIV=4, GAP_TICKS=1, ADDR_W=3):
- ROM {C dur 2, END}, pulse start → play_note high with hz=191109 for exactly 8 cycles starting 3 cycles after start, then low for 4 gap cycles, done pulses once, busy falls.
- ROM {rest dur 1, E dur 1, END} → play_note low for 4+4+2 cycles, then high with hz=151685 for 4 cycles.
- Pause for 5 cycles mid-note on {G dur 3, END} → play_note 0 during the pause, total high time still 12 cycles, hz=127551 throughout.
- loop_en=1 with {A dur 1, END} → A repeats indefinitely with a period of 4+4+2+2 = 12 cycles, and done never pulses.
- Stop during PLAY → play_note 0 and busy 0 the next cycle. Start and stop asserted together from IDLE → remains IDLE.
- resetn low mid-note → all outputs 0 immediately (asynchronously). Eight nonzero non-END events with loop_en=0 → address wrap causes done after event 7.
